// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, constants and lane helpers for regfile_mp
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  localparam int RF_A0_IDX = 10;

  // Bit offset of a lane/port field inside a packed multi-lane bus
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy scoreboard with set-over-clear priority
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_WR     = 2,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_en,
  input  logic [NUM_WR-1:0]            i_we,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] i_wa,
  input  logic [NUM_WR-1:0]            i_rsv,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] i_rsv_addr,
  output logic [DEPTH-1:0]             o_busy
);

  logic [DEPTH-1:0]      r_busy;
  logic [DEPTH-1:0]      w_busy_nxt;
  logic [ADDR_WIDTH-1:0] w_addr;

  // Clears from writeback first, then reservations so a same-cycle set wins
  always_comb begin
    w_busy_nxt = r_busy;
    w_addr     = '0;
    if (i_en) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (i_we[k]) begin
          w_addr             = i_wa[lane_lsb(k, ADDR_WIDTH) +: ADDR_WIDTH];
          w_busy_nxt[w_addr] = 1'b0;
        end
      end
      for (int k = 0; k < NUM_WR; k++) begin
        if (i_rsv[k]) begin
          w_addr             = i_rsv_addr[lane_lsb(k, ADDR_WIDTH) +: ADDR_WIDTH];
          w_busy_nxt[w_addr] = 1'b1;
        end
      end
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Busy vector register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_busy <= '0;
    else          r_busy <= w_busy_nxt;
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with clear engine, bypass and scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 4,
  parameter int NUM_WR     = 2,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_WR-1:0]            we_i,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wa_i,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wd_i,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] ra_i,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_o,
  input  logic [NUM_WR-1:0]            rsv_i,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] rsv_addr_i,
  output logic [2**ADDR_WIDTH-1:0]     busy_o,
  output logic                         init_done_o,
  output logic [DATA_WIDTH-1:0]        a0_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  rf_state_e             r_state;
  rf_state_e             w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_ptr;
  logic                  w_run;

  // Entry 0 exists only to keep indexing simple; it is never written or read
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [ADDR_WIDTH-1:0] w_wa [NUM_WR];
  logic [DATA_WIDTH-1:0] w_wd [NUM_WR];
  logic [ADDR_WIDTH-1:0] w_ra [NUM_RD];

  // Unpack lane buses into per-lane views
  always_comb begin
    for (int k = 0; k < NUM_WR; k++) begin
      w_wa[k] = wa_i[lane_lsb(k, ADDR_WIDTH) +: ADDR_WIDTH];
      w_wd[k] = wd_i[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH];
    end
    for (int p = 0; p < NUM_RD; p++) begin
      w_ra[p] = ra_i[lane_lsb(p, ADDR_WIDTH) +: ADDR_WIDTH];
    end
  end

  // FSM state and clear pointer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= RF_CLEAR;
      r_clr_ptr <= ADDR_WIDTH'(1);
    end else begin
      r_state <= w_state_nxt;
      if (r_state == RF_CLEAR) r_clr_ptr <= r_clr_ptr + ADDR_WIDTH'(1);
    end
  end

  // Next state: leave CLEAR on the cycle that zeroes the last register
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RF_CLEAR: if (r_clr_ptr == LAST_IDX) w_state_nxt = RF_RUN;
      RF_RUN:   w_state_nxt = RF_RUN;
      default:  w_state_nxt = RF_CLEAR;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_run       = (r_state == RF_RUN);
    init_done_o = w_run;
  end

  // Array update: clear engine during CLEAR, prioritised lane writes in RUN
  always_ff @(posedge clk) begin
    if (r_state == RF_CLEAR) begin
      r_mem[r_clr_ptr] <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (we_i[k] && (w_wa[k] != '0)) r_mem[w_wa[k]] <= w_wd[k];
      end
    end
  end

  // Read ports: x0 and CLEAR read as zero, later lanes override earlier in bypass
  always_comb begin
    rd_o = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (w_run && (w_ra[p] != '0)) begin
        rd_o[lane_lsb(p, DATA_WIDTH) +: DATA_WIDTH] = r_mem[w_ra[p]];
        if (BYPASS) begin
          for (int k = 0; k < NUM_WR; k++) begin
            if (we_i[k] && (w_wa[k] == w_ra[p]))
              rd_o[lane_lsb(p, DATA_WIDTH) +: DATA_WIDTH] = w_wd[k];
          end
        end
      end
    end
  end

  // a0 tap reflects only the stored value
  always_comb begin
    a0_o = w_run ? r_mem[RF_A0_IDX] : '0;
  end

  rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_WR     (NUM_WR),
    .DEPTH      (DEPTH)
  ) u_scoreboard (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_en       (w_run),
    .i_we       (we_i),
    .i_wa       (wa_i),
    .i_rsv      (rsv_i),
    .i_rsv_addr (rsv_addr_i),
    .o_busy     (busy_o)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic [19:0] ra;
  logic [1:0]  rsv;
  logic [9:0]  rsv_addr;

  logic [127:0] rd_b, rd_n;
  logic [31:0]  busy_b, busy_n;
  logic         done_b, done_n;
  logic [31:0]  a0_b, a0_n;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n), .we_i(we), .wa_i(wa), .wd_i(wd), .ra_i(ra),
    .rd_o(rd_b), .rsv_i(rsv), .rsv_addr_i(rsv_addr), .busy_o(busy_b),
    .init_done_o(done_b), .a0_o(a0_b)
  );

  regfile_mp #(.BYPASS(1'b0)) u_nbp (
    .clk(clk), .reset_n(reset_n), .we_i(we), .wa_i(wa), .wd_i(wd), .ra_i(ra),
    .rd_o(rd_n), .rsv_i(rsv), .rsv_addr_i(rsv_addr), .busy_o(busy_n),
    .init_done_o(done_n), .a0_o(a0_n)
  );

  task automatic idle();
    we = '0; wa = '0; wd = '0; rsv = '0; rsv_addr = '0;
  endtask

  task automatic test_reset();
    int cnt;
    reset_n = 1'b0;
    idle();
    ra = {5'd4, 5'd3, 5'd2, 5'd5};
    repeat (3) @(negedge clk);
    n_cmp++; if (done_b !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%0b exp=0", done_b); end
    n_cmp++; if (busy_b !== 32'h0) begin n_bad++; $display("FAIL reset_busy got=%h exp=0", busy_b); end
    n_cmp++; if (rd_b !== 128'h0) begin n_bad++; $display("FAIL reset_rd got=%h exp=0", rd_b); end
    n_cmp++; if (a0_b !== 32'h0) begin n_bad++; $display("FAIL reset_a0 got=%h exp=0", a0_b); end
    // traffic during CLEAR must be ignored
    we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'h0, 32'hDEAD_BEEF};
    rsv = 2'b01; rsv_addr = {5'd0, 5'd5};
    reset_n = 1'b1;
    cnt = 0;
    while (done_b !== 1'b1 && cnt < 100) begin
      @(posedge clk); #1; cnt++;
      if (cnt == 1) begin
        n_cmp++; if (rd_b[31:0] !== 32'h0) begin n_bad++; $display("FAIL clear_rd got=%h exp=0", rd_b[31:0]); end
      end
    end
    n_cmp++; if (cnt !== 31) begin n_bad++; $display("FAIL init_latency got=%0d exp=31", cnt); end
    @(negedge clk);
    idle();
    #1;
    n_cmp++; if (rd_b[31:0] !== 32'h0) begin n_bad++; $display("FAIL x5_after_init got=%h exp=0", rd_b[31:0]); end
    n_cmp++; if (busy_b !== 32'h0) begin n_bad++; $display("FAIL busy_after_init got=%h exp=0", busy_b); end
    n_cmp++; if (done_n !== 1'b1) begin n_bad++; $display("FAIL nbp_done got=%0b exp=1", done_n); end
  endtask

  task automatic test_write_conflict();
    @(negedge clk);
    we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h22, 32'h11};
    ra = {5'd0, 5'd0, 5'd0, 5'd7};
    #1;
    n_cmp++; if (rd_b[31:0] !== 32'h22) begin n_bad++; $display("FAIL bypass_conflict got=%h exp=22", rd_b[31:0]); end
    n_cmp++; if (rd_n[31:0] !== 32'h0) begin n_bad++; $display("FAIL nobypass_old got=%h exp=0", rd_n[31:0]); end
    @(negedge clk);
    idle();
    #1;
    n_cmp++; if (rd_b[31:0] !== 32'h22) begin n_bad++; $display("FAIL stored_conflict got=%h exp=22", rd_b[31:0]); end
    n_cmp++; if (rd_n[31:0] !== 32'h22) begin n_bad++; $display("FAIL nbp_stored got=%h exp=22", rd_n[31:0]); end
  endtask

  task automatic test_x0();
    @(negedge clk);
    we = 2'b01; wa = {5'd0, 5'd0}; wd = {32'h0, 32'hFFFF_FFFF};
    rsv = 2'b01; rsv_addr = {5'd0, 5'd0};
    ra = {5'd0, 5'd0, 5'd0, 5'd0};
    #1;
    n_cmp++; if (rd_b[31:0] !== 32'h0) begin n_bad++; $display("FAIL x0_bypass got=%h exp=0", rd_b[31:0]); end
    @(negedge clk);
    idle();
    #1;
    n_cmp++; if (rd_b[31:0] !== 32'h0) begin n_bad++; $display("FAIL x0_stored got=%h exp=0", rd_b[31:0]); end
    n_cmp++; if (busy_b !== 32'h0) begin n_bad++; $display("FAIL x0_busy got=%h exp=0", busy_b); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    rsv = 2'b01; rsv_addr = {5'd0, 5'd10};
    @(negedge clk);
    idle();
    #1;
    n_cmp++; if (busy_b !== 32'h0000_0400) begin n_bad++; $display("FAIL rsv_x10 got=%h exp=00000400", busy_b); end
    @(negedge clk);
    we = 2'b01; wa = {5'd0, 5'd10}; wd = {32'h0, 32'h1234};
    rsv = 2'b10; rsv_addr = {5'd10, 5'd0};
    #1;
    n_cmp++; if (a0_b !== 32'h0) begin n_bad++; $display("FAIL a0_not_bypassed got=%h exp=0", a0_b); end
    @(negedge clk);
    idle();
    #1;
    n_cmp++; if (busy_b !== 32'h0000_0400) begin n_bad++; $display("FAIL set_beats_clear got=%h exp=00000400", busy_b); end
    n_cmp++; if (a0_b !== 32'h1234) begin n_bad++; $display("FAIL a0_stored got=%h exp=1234", a0_b); end
    @(negedge clk);
    we = 2'b01; wa = {5'd0, 5'd10}; wd = {32'h0, 32'h1234};
    @(negedge clk);
    idle();
    #1;
    n_cmp++; if (busy_b !== 32'h0) begin n_bad++; $display("FAIL write_clears_busy got=%h exp=0", busy_b); end
    n_cmp++; if (a0_b !== 32'h1234) begin n_bad++; $display("FAIL a0_final got=%h exp=1234", a0_b); end
  endtask

  task automatic test_four_ports();
    @(negedge clk);
    we = 2'b11; wa = {5'd2, 5'd1}; wd = {32'hA2, 32'hA1};
    @(negedge clk);
    we = 2'b11; wa = {5'd4, 5'd3}; wd = {32'hA4, 32'hA3};
    @(negedge clk);
    idle();
    ra = {5'd1, 5'd2, 5'd3, 5'd4};
    #1;
    n_cmp++; if (rd_b !== {32'hA1, 32'hA2, 32'hA3, 32'hA4}) begin n_bad++; $display("FAIL four_ports got=%h exp=a1a2a3a4", rd_b); end
    n_cmp++; if (rd_n !== {32'hA1, 32'hA2, 32'hA3, 32'hA4}) begin n_bad++; $display("FAIL four_ports_nbp got=%h exp=a1a2a3a4", rd_n); end
  endtask

  task automatic test_reset_mid();
    int cnt;
    @(negedge clk);
    we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'h0, 32'h55};
    rsv = 2'b10; rsv_addr = {5'd12, 5'd0};
    @(negedge clk);
    idle();
    ra = {5'd0, 5'd0, 5'd0, 5'd3};
    #1;
    n_cmp++; if (rd_b[31:0] !== 32'h55) begin n_bad++; $display("FAIL x3_before_reset got=%h exp=55", rd_b[31:0]); end
    n_cmp++; if (busy_b !== 32'h0000_1000) begin n_bad++; $display("FAIL busy_before_reset got=%h exp=00001000", busy_b); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (done_b !== 1'b0) begin n_bad++; $display("FAIL mid_reset_done got=%0b exp=0", done_b); end
    n_cmp++; if (rd_b[31:0] !== 32'h0) begin n_bad++; $display("FAIL mid_reset_x3 got=%h exp=0", rd_b[31:0]); end
    n_cmp++; if (busy_b !== 32'h0) begin n_bad++; $display("FAIL mid_reset_busy got=%h exp=0", busy_b); end
    n_cmp++; if (a0_b !== 32'h0) begin n_bad++; $display("FAIL mid_reset_a0 got=%h exp=0", a0_b); end
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    while (done_b !== 1'b1 && cnt < 100) begin
      @(posedge clk); #1; cnt++;
    end
    n_cmp++; if (cnt !== 31) begin n_bad++; $display("FAIL reinit_latency got=%0d exp=31", cnt); end
    n_cmp++; if (rd_b[31:0] !== 32'h0) begin n_bad++; $display("FAIL x3_after_reinit got=%h exp=0", rd_b[31:0]); end
    n_cmp++; if (a0_b !== 32'h0) begin n_bad++; $display("FAIL a0_after_reinit got=%h exp=0", a0_b); end
  endtask

  initial begin
    test_reset();
    test_write_conflict();
    test_x0();
    test_scoreboard();
    test_four_ports();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
